// File: rtl/alu_control_mdu_pkg.sv
// Shared encodings for the EX-stage ALU decoder and the multiply/divide unit.
package alu_control_mdu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [2:0] AOP_ADD   = 3'b000;
  localparam logic [2:0] AOP_SUB   = 3'b001;
  localparam logic [2:0] AOP_RTYPE = 3'b010;
  localparam logic [2:0] AOP_AND   = 3'b011;
  localparam logic [2:0] AOP_OR    = 3'b100;
  localparam logic [2:0] AOP_XOR   = 3'b101;
  localparam logic [2:0] AOP_SLT   = 3'b110;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} mdu_state_e;

  function automatic logic is_mdu_funct(input logic [5:0] f);
    return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/alu_control_mdu_core.sv
// Iterative multiply/divide engine: shift-add multiply, restoring divide,
// sign fix-up in a final cycle, plus the architectural HI/LO registers.
module mdu_core
  import alu_control_mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept_i,
  input  logic [5:0]        funct_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CW = $clog2(DATA_W);

  mdu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, rs_q, rs_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              nlo_q, nlo_d, nhi_q, nhi_d, dz_q, dz_d, div_q, div_d;

  logic              sgn, rs_neg, rt_neg;
  logic [DATA_W-1:0] rs_mag, rt_mag;
  logic [DATA_W:0]   add_sum, shl, diff;
  logic [2*DATA_W-1:0] prod_fix;

  always_comb begin
    sgn     = (funct_i == F_MULT) || (funct_i == F_DIV);
    rs_neg  = sgn & rs_i[DATA_W-1];
    rt_neg  = sgn & rt_i[DATA_W-1];
    rs_mag  = rs_neg ? -rs_i : rs_i;
    rt_mag  = rt_neg ? -rt_i : rt_i;
    add_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
    shl     = {acc_q, b_q[DATA_W-1]};
    diff    = shl - {1'b0, a_q};
    prod_fix = nlo_q ? -{acc_q, b_q} : {acc_q, b_q};

    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rs_d    = rs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    nlo_d   = nlo_q;
    nhi_d   = nhi_q;
    dz_d    = dz_q;
    div_d   = div_q;

    unique case (state_q)
      ST_IDLE: if (accept_i) begin
        case (funct_i)
          F_MTHI: hi_d = rs_i;
          F_MTLO: lo_d = rs_i;
          F_MULT, F_MULTU: begin
            a_d     = rs_mag;
            b_d     = rt_mag;
            acc_d   = '0;
            cnt_d   = '0;
            nlo_d   = rs_neg ^ rt_neg;
            div_d   = 1'b0;
            state_d = ST_MUL;
          end
          F_DIV, F_DIVU: begin
            a_d     = rt_mag;
            b_d     = rs_mag;
            acc_d   = '0;
            cnt_d   = '0;
            rs_d    = rs_i;
            nlo_d   = rs_neg ^ rt_neg;
            nhi_d   = rs_neg;
            dz_d    = (rt_i == '0);
            div_d   = 1'b1;
            state_d = ST_DIV;
          end
          default: ;
        endcase
      end
      ST_MUL: begin
        // product accumulates in {acc,b}; multiplier bits shift out of b
        acc_d = add_sum[DATA_W:1];
        b_d   = {add_sum[0], b_q[DATA_W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W-1)) state_d = ST_FIX;
      end
      ST_DIV: begin
        // dividend bits shift out of b as quotient bits shift in
        if (!diff[DATA_W]) begin
          acc_d = diff[DATA_W-1:0];
          b_d   = {b_q[DATA_W-2:0], 1'b1};
        end else begin
          acc_d = shl[DATA_W-1:0];
          b_d   = {b_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W-1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (!div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_q) begin
          lo_d = '1;
          hi_d = rs_q;
        end else begin
          lo_d = nlo_q ? -b_q : b_q;
          hi_d = nhi_q ? -acc_q : acc_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush_i) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rs_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      nlo_q   <= 1'b0;
      nhi_q   <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rs_q    <= rs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      nlo_q   <= nlo_d;
      nhi_q   <= nhi_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decode with an attached multiply/divide unit and the
// stall handshake that holds IF/ID/EX while the MDU is iterating.
module alu_control_mdu
  import alu_control_mdu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            alu_op,
  input  logic [5:0]            funct,
  input  logic                  ex_valid,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     rs_val,
  input  logic [DATA_W-1:0]     rt_val,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  mdu_sel,
  output logic [DATA_W-1:0]     mdu_result,
  output logic                  stall,
  output logic                  busy,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo
);

  logic [3:0] ctrl;
  logic       mdu_op, accept, is_mf;

  always_comb begin
    ctrl = ALU_ADD;
    case (alu_op)
      AOP_ADD: ctrl = ALU_ADD;
      AOP_SUB: ctrl = ALU_SUB;
      AOP_AND: ctrl = ALU_AND;
      AOP_OR:  ctrl = ALU_OR;
      AOP_XOR: ctrl = ALU_XOR;
      AOP_SLT: ctrl = ALU_SLT;
      AOP_RTYPE: begin
        case (funct)
          F_ADD:   ctrl = ALU_ADD;
          F_SUB:   ctrl = ALU_SUB;
          F_AND:   ctrl = ALU_AND;
          F_OR:    ctrl = ALU_OR;
          F_SLT:   ctrl = ALU_SLT;
          F_XOR:   ctrl = ALU_XOR;
          F_NOR:   ctrl = ALU_NOR;
          F_SLTU:  ctrl = ALU_SLTU;
          default: ctrl = ALU_AND;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(ctrl);

  assign mdu_op = ex_valid && (alu_op == AOP_RTYPE) && is_mdu_funct(funct);
  assign stall  = mdu_op & busy;
  assign accept = mdu_op & ~stall & ~flush;
  assign is_mf  = (funct == F_MFHI) || (funct == F_MFLO);

  assign mdu_sel    = mdu_op & ~stall & is_mf;
  assign mdu_result = !mdu_sel ? '0 : (funct == F_MFHI) ? hi : lo;

  mdu_core #(.DATA_W(DATA_W)) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .accept_i (accept),
    .funct_i  (funct),
    .flush_i  (flush),
    .rs_i     (rs_val),
    .rt_i     (rt_val),
    .busy_o   (busy),
    .hi_o     (hi),
    .lo_o     (lo)
  );

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode table, MDU result table, and
// hand-written stall / flush / reset sequences.
module tb_alu_control_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic        ex_valid, flush;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  alu_control;
  logic        mdu_sel, stall, busy;
  logic [31:0] mdu_result, hi, lo;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  alu_control_mdu #(.DATA_W(32), .ALU_CTRL_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_op      (alu_op),
    .funct       (funct),
    .ex_valid    (ex_valid),
    .flush       (flush),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .alu_control (alu_control),
    .mdu_sel     (mdu_sel),
    .mdu_result  (mdu_result),
    .stall       (stall),
    .busy        (busy),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] exp;
  } dec_t;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] rs, rt, ehi, elo;
  } mdu_t;

  dec_t dv[15];
  mdu_t mv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; alu_op = 3'b000; funct = 6'd0; flush = 1'b0;
  endtask

  task automatic drive(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    ex_valid = 1'b1; alu_op = 3'b010; funct = fn; rs_val = rs; rt_val = rt;
  endtask

  // counts negedges with the given signal high, bounded
  task automatic count_high(input bit use_stall, output int n);
    n = 0;
    while ((use_stall ? stall : busy) && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; rs_val = '0; rt_val = '0;
    idle_inputs();

    dv[0]  = '{3'b010, 6'b100000, 4'b0010};
    dv[1]  = '{3'b010, 6'b100010, 4'b0110};
    dv[2]  = '{3'b010, 6'b100100, 4'b0000};
    dv[3]  = '{3'b010, 6'b100101, 4'b0001};
    dv[4]  = '{3'b010, 6'b101010, 4'b0111};
    dv[5]  = '{3'b010, 6'b100110, 4'b0011};
    dv[6]  = '{3'b010, 6'b100111, 4'b1100};
    dv[7]  = '{3'b010, 6'b101011, 4'b1000};
    dv[8]  = '{3'b010, 6'b010000, 4'b0000};
    dv[9]  = '{3'b010, 6'b111111, 4'b0000};
    dv[10] = '{3'b101, 6'b000000, 4'b0011};
    dv[11] = '{3'b000, 6'b100010, 4'b0010};
    dv[12] = '{3'b001, 6'b000000, 4'b0110};
    dv[13] = '{3'b011, 6'b000000, 4'b0000};
    dv[14] = '{3'b100, 6'b000000, 4'b0001};

    mv[0] = '{6'b011000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    mv[1] = '{6'b011001, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    mv[2] = '{6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    mv[3] = '{6'b011011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    mv[4] = '{6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    mv[5] = '{6'b011010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    mv[6] = '{6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    mv[7] = '{6'b011010, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};

    #2;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ex_valid = 1'b1; alu_op = dv[i].op; funct = dv[i].fn;
      #1;
      chk($sformatf("decode[%0d]", i), {28'd0, alu_control}, {28'd0, dv[i].exp});
      chk($sformatf("decode stall[%0d]", i), {31'd0, stall}, 32'd0);
    end
    idle_inputs();

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(mv[i].fn, mv[i].rs, mv[i].rt);
      @(negedge clk);
      idle_inputs();
      count_high(1'b0, n);
      chk($sformatf("mdu[%0d] busy cycles", i), n, 33);
      chk($sformatf("mdu[%0d] hi", i), hi, mv[i].ehi);
      chk($sformatf("mdu[%0d] lo", i), lo, mv[i].elo);
    end

    // MULT immediately followed by MFLO: read stalls, then returns new LO
    @(negedge clk);
    drive(6'b011000, 32'd5, 32'd7);
    @(negedge clk);
    drive(6'b010010, 32'd0, 32'd0);
    #1;
    chk("mflo sel while stalled", {31'd0, mdu_sel}, 32'd0);
    @(negedge clk);
    count_high(1'b1, n);
    chk("mflo stall cycles", n + 1, 33);
    chk("mflo sel", {31'd0, mdu_sel}, 32'd1);
    chk("mflo result", mdu_result, 32'd35);
    idle_inputs();

    // non-MDU op while busy never stalls
    @(negedge clk);
    drive(6'b011001, 32'd9, 32'd9);
    @(negedge clk);
    drive(6'b100000, 32'd0, 32'd0);
    #1;
    chk("add while busy stall", {31'd0, stall}, 32'd0);
    chk("add while busy busy", {31'd0, busy}, 32'd1);
    chk("add while busy ctrl", {28'd0, alu_control}, 32'd2);
    idle_inputs();
    count_high(1'b0, n);
    chk("mult 9*9 lo", lo, 32'd81);

    // back-to-back: second MULTU waits for IDLE then runs in full
    @(negedge clk);
    drive(6'b011000, 32'd2, 32'd3);
    @(negedge clk);
    drive(6'b011001, 32'd4, 32'd5);
    count_high(1'b1, n);
    chk("b2b stall cycles", n, 33);
    chk("b2b first lo", lo, 32'd6);
    @(negedge clk);
    idle_inputs();
    chk("b2b second busy", {31'd0, busy}, 32'd1);
    count_high(1'b0, n);
    chk("b2b second lo", lo, 32'd20);

    // MTHI / MTLO then read back
    @(negedge clk);
    drive(6'b010001, 32'h12345678, 32'd0);
    @(negedge clk);
    drive(6'b010000, 32'd0, 32'd0);
    #1;
    chk("mfhi after mthi", mdu_result, 32'h12345678);
    chk("mfhi sel", {31'd0, mdu_sel}, 32'd1);
    @(negedge clk);
    drive(6'b010011, 32'hCAFEF00D, 32'd0);
    @(negedge clk);
    drive(6'b010010, 32'd0, 32'd0);
    #1;
    chk("mflo after mtlo", mdu_result, 32'hCAFEF00D);
    idle_inputs();

    // flush on iteration 10 of a DIV discards it
    @(negedge clk);
    drive(6'b011011, 32'd100, 32'd7);
    @(negedge clk);
    idle_inputs();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush hi", hi, 32'h12345678);
    chk("flush lo", lo, 32'hCAFEF00D);

    // flush in IDLE blocks acceptance
    drive(6'b010011, 32'h11111111, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("flush blocks mtlo", lo, 32'hCAFEF00D);
    drive(6'b011000, 32'd3, 32'd3);
    flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("flush blocks mult", {31'd0, busy}, 32'd0);

    // async reset during MUL iteration 5
    drive(6'b011000, 32'd6, 32'd7);
    @(negedge clk);
    drive(6'b010010, 32'd0, 32'd0);
    repeat (4) @(negedge clk);
    chk("pre-reset stall", {31'd0, stall}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset hi", hi, 32'h0);
    chk("async reset lo", lo, 32'h0);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    drive(6'b011000, 32'd3, 32'd4);
    @(negedge clk);
    idle_inputs();
    count_high(1'b0, n);
    chk("post-reset mult lo", lo, 32'd12);
    chk("post-reset mult hi", hi, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
- Parametrised successor to the EX-stage ALU decoder. Adds an iterative multiply/divide unit (MDU) with HI/LO registers and a pipeline stall handshake.
- Combinationally decodes alu_op/funct into the 4-bit ALU operation code, with R-type coverage extended by XOR, NOR and SLTU.
- Sequences MULT/MULTU/DIV/DIVU over multiple cycles and serves MFHI/MFLO/MTHI/MTLO.
- Sits in the EX stage beside the ALU; its stall output freezes IF/ID/EX.

Parameters:
DATA_W, 32, operand/HI/LO width; must be even and >= 8
ALU_CTRL_W, 4, width of alu_control

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
alu_op  input  3  main-control ALU class (same encoding as the existing decoder)
funct  input  6  instruction funct field
ex_valid  input  1  EX stage holds a valid, non-bubble instruction
flush  input  1  abort any in-flight MDU operation (branch/exception squash)
rs_val  input  DATA_W  forwarded rs operand
rt_val  input  DATA_W  forwarded rt operand
alu_control  output  ALU_CTRL_W  ALU operation code (combinational)
mdu_sel  output  1  EX result must come from mdu_result (MFHI/MFLO)
mdu_result  output  DATA_W  HI for MFHI, LO for MFLO, else 0
stall  output  1  hold the pipeline this cycle
busy  output  1  MDU iterating (state != IDLE)
hi  output  DATA_W  HI register
lo  output  DATA_W  LO register

Behaviour:
- alu_control decode is combinational and unchanged for alu_op 000..110.
- R-type (alu_op 010) funct mapping:
  - ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111 (unchanged)
  - XOR 100110 -> 0011, NOR 100111 -> 1100, SLTU 101011 -> 1000
  - MDU functs -> 0000; default 0000.
- MDU functs (only when alu_op == 010):
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
- mdu_op = ex_valid & alu_op==010 & funct is an MDU funct.
- stall = mdu_op & (state != IDLE), combinational. Non-MDU instructions never stall.
- State machine: IDLE, MUL, DIV, FIX.
  - IDLE: on mdu_op, not stalling and not flush:
    - MULT/MULTU or DIV/DIVU: latch operand magnitudes (absolute values for signed ops), result-sign flags and the divide-by-zero flag; clear the iteration counter; go to MUL or DIV.
    - MTHI/MTLO: write rs_val into HI/LO at this edge; stay in IDLE.
  - MUL: radix-2 shift-add, one bit per cycle, DATA_W cycles; then FIX.
  - DIV: restoring shift-subtract, one quotient bit per cycle, DATA_W cycles; then FIX.
  - FIX: apply two's-complement sign correction and write HI/LO at this edge; go to IDLE.
- Latency: accept edge + DATA_W iterations + FIX = HI/LO updated at the (DATA_W+1)th edge after accept. busy is high for DATA_W+1 cycles.
- Result rules:
  - MULT(U): {HI,LO} = full 2*DATA_W product.
  - DIV(U): LO = quotient, HI = remainder.
  - Signed remainder takes the sign of the dividend.
  - Divide by zero (signed or unsigned): LO = all ones, HI = rs_val as latched; full latency still applies.
  - Signed most-negative / -1: LO = most-negative, HI = 0.
- MFHI/MFLO: mdu_sel = 1 and mdu_result = current hi/lo, only when not stalling. A read issued while busy stalls until IDLE, then returns the new value.
- flush:
  - Forces IDLE at the next edge; HI/LO unchanged; in-flight result discarded.
  - In IDLE, flush blocks acceptance of that cycle's MDU op.
- Back-to-back MDU ops: a second MULT/DIV arriving while busy stalls and is accepted in the first IDLE cycle.
- Reset (asynchronous): state IDLE, hi = lo = 0, counter and datapath registers 0, busy = 0. stall = 0 while reset is held. Reset mid-operation discards the operation.

Decomposition:
- Shared package holds:
  - ALU control code constants: ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_NOR
  - alu_op class constants
  - R-type funct constants, including all MDU functs
  - MDU state enum
- One sub-module: mdu_core (state machine, counter, shift datapath, HI/LO). The top level keeps the decode and the stall/mdu_sel logic.

Test Plan:
- R-type decode sweep: alu_op=010 with funct 100110/100111/101011 -> alu_control 0011/1100/1000; alu_op=101 -> 0011; stall=0 throughout.
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA. busy high exactly 33 cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT followed immediately by MFLO -> stall=1 for 33 cycles, then mdu_sel=1 and mdu_result equals the new LO. A non-MDU ADD issued while busy -> stall=0.
- MTHI 0x12345678 then MFHI the next cycle -> mdu_result=0x12345678. flush on iteration 10 of a DIV -> IDLE next edge, HI/LO keep their prior values.
- Assert reset asynchronously during MUL iteration 5 -> hi=lo=0, busy=0 immediately. After release, a MULT 3*4 gives LO=12, HI=0.
